// File: rtl/parity_frame_checker_pkg.sv
// ============================================================================
// Module   : parity_pkg
// Purpose  : Shared frame states and parity-mode constants for the checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } frame_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/parity_frame_checker_if.sv
// ============================================================================
// Module   : parity_frame_checker_if
// Purpose  : Serial bit-stream handshake into the parity frame checker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface parity_frame_checker_if;

    logic in_valid;
    logic in_bit;
    logic in_sof;
    logic odd_mode;

    modport master (output in_valid, output in_bit, output in_sof, output odd_mode);
    modport slave  (input  in_valid, input  in_bit, input  in_sof, input  odd_mode);

endinterface

`default_nettype wire

// File: rtl/parity_frame_checker_sat_counter.sv
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter that sticks at all-ones; cleared only by reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             inc,
    output logic [WIDTH-1:0]      count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/parity_frame_checker.sv
// ============================================================================
// Module   : parity_frame_checker
// Purpose  : Serial even/odd parity checker with word reassembly and error count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_frame_checker
    import parity_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CNT_BITS  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    parity_frame_checker_if.slave     bus,
    output logic [DATA_BITS-1:0]      data_out,
    output logic                      frame_valid,
    output logic                      parity_err,
    output logic                      framing_err,
    output logic                      running_parity,
    output logic                      busy,
    output logic [CNT_BITS-1:0]       err_count
);

    localparam int CW = $clog2(DATA_BITS + 1);

    frame_state_t          r_state,  w_state_nxt;
    logic [DATA_BITS-1:0]  r_data,   w_data_nxt;
    logic [CW-1:0]         r_cnt,    w_cnt_nxt;
    logic                  r_rp,     w_rp_nxt;
    logic                  r_mode,   w_mode_nxt;
    logic                  r_fv,     w_fv_nxt;
    logic                  r_pe,     w_pe_nxt;
    logic                  r_fe,     w_fe_nxt;
    logic                  w_err_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_cnt   <= '0;
            r_rp    <= 1'b0;
            r_mode  <= PAR_EVEN;
            r_fv    <= 1'b0;
            r_pe    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rp    <= w_rp_nxt;
            r_mode  <= w_mode_nxt;
            r_fv    <= w_fv_nxt;
            r_pe    <= w_pe_nxt;
            r_fe    <= w_fe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_cnt_nxt   = r_cnt;
        w_rp_nxt    = r_rp;
        w_mode_nxt  = r_mode;
        w_fv_nxt    = 1'b0;
        w_pe_nxt    = r_pe;
        w_fe_nxt    = 1'b0;

        if (bus.in_valid) begin
            if (bus.in_sof) begin
                // SOF always restarts; arriving mid-frame it also drops the partial frame
                w_fe_nxt      = (r_state != IDLE);
                w_data_nxt[0] = bus.in_bit;
                w_rp_nxt      = bus.in_bit;
                w_mode_nxt    = bus.odd_mode;
                w_cnt_nxt     = CW'(1);
                w_state_nxt   = (DATA_BITS == 1) ? PARITY : DATA;
            end else begin
                case (r_state)
                    DATA: begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (r_cnt == CW'(i)) begin
                                w_data_nxt[i] = bus.in_bit;
                            end
                        end
                        w_rp_nxt  = r_rp ^ bus.in_bit;
                        w_cnt_nxt = r_cnt + CW'(1);
                        if (r_cnt == CW'(DATA_BITS - 1)) begin
                            w_state_nxt = PARITY;
                        end
                    end
                    PARITY: begin
                        w_pe_nxt    = r_rp ^ bus.in_bit ^ r_mode;
                        w_fv_nxt    = 1'b1;
                        w_rp_nxt    = 1'b0;
                        w_state_nxt = IDLE;
                    end
                    default: begin
                        w_state_nxt = r_state;
                    end
                endcase
            end
        end
    end

    // Count from next-state values so err_count moves together with the pulse
    assign w_err_inc = (w_fv_nxt & w_pe_nxt) | w_fe_nxt;

    sat_counter #(
        .WIDTH (CNT_BITS)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_err_inc),
        .count (err_count)
    );

    assign data_out       = r_data;
    assign frame_valid    = r_fv;
    assign parity_err     = r_pe;
    assign framing_err    = r_fe;
    assign running_parity = r_rp;
    assign busy           = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
// ============================================================================
// Module   : tb_parity_frame_checker
// Purpose  : Scoreboard bench for the parity frame checker (8 data bits, 2-bit count).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_frame_checker;

    localparam int DB = 8;
    localparam int CB = 2;

    typedef struct {
        logic [DB-1:0] d;
        logic          pe;
        logic [CB-1:0] cnt;
    } fv_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] data_out;
    logic          frame_valid, parity_err, framing_err, running_parity, busy;
    logic [CB-1:0] err_count;

    int            checks = 0;
    int            errors = 0;
    fv_exp_t       fvq[$];
    logic [CB-1:0] feq[$];
    logic [CB-1:0] exp_cnt = '0;

    parity_frame_checker_if bus ();

    parity_frame_checker #(
        .DATA_BITS (DB),
        .CNT_BITS  (CB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .data_out       (data_out),
        .frame_valid    (frame_valid),
        .parity_err     (parity_err),
        .framing_err    (framing_err),
        .running_parity (running_parity),
        .busy           (busy),
        .err_count      (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [CB-1:0] sat_inc(input logic [CB-1:0] c);
        return (c == {CB{1'b1}}) ? c : c + CB'(1);
    endfunction

    // Monitor: every pulse must match the head of its expectation queue
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_valid) begin
                if (fvq.size() == 0) begin
                    chk("unexpected_frame_valid", 32'd1, 32'd0);
                end else begin
                    fv_exp_t e;
                    e = fvq.pop_front();
                    chk("data_out", 32'(data_out), 32'(e.d));
                    chk("parity_err", 32'(parity_err), 32'(e.pe));
                    chk("err_count_fv", 32'(err_count), 32'(e.cnt));
                end
            end
            if (framing_err) begin
                if (feq.size() == 0) begin
                    chk("unexpected_framing_err", 32'd1, 32'd0);
                end else begin
                    logic [CB-1:0] c;
                    c = feq.pop_front();
                    chk("err_count_fe", 32'(err_count), 32'(c));
                end
            end
        end
    end

    task automatic drive(input logic sof, input logic b, input logic m);
        bus.in_valid = 1'b1;
        bus.in_sof   = sof;
        bus.in_bit   = b;
        bus.odd_mode = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    // Stall cycles with garbage on the qualified lines
    task automatic idle(input int n, input bit chk_busy);
        for (int k = 0; k < n; k++) begin
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'($urandom_range(0, 1));
            bus.in_bit   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (chk_busy) chk("busy_in_gap", 32'(busy), 32'd1);
        end
        bus.in_sof = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_parity_err", 32'(parity_err), 32'd0);
        chk("rst_framing_err", 32'(framing_err), 32'd0);
        chk("rst_running_parity", 32'(running_parity), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic partial(input int n, input logic m);
        drive(1'b1, 1'b1, m);
        for (int k = 1; k < n; k++) drive(1'b0, 1'($urandom_range(0, 1)), m);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic m,
                              input bit gaps, input bit mid);
        fv_exp_t e;
        logic    rp;
        if (mid) begin
            exp_cnt = sat_inc(exp_cnt);
            feq.push_back(exp_cnt);
        end
        drive(1'b1, d[0], m);
        rp = d[0];
        if (gaps) chk("busy_after_sof", 32'(busy), 32'd1);
        for (int k = 1; k < DB; k++) begin
            if (gaps) idle($urandom_range(0, 2), 1'b1);
            // Flip odd_mode on data bits: only the SOF value may count
            drive(1'b0, d[k], ~m);
            rp = rp ^ d[k];
            if (gaps) chk("busy_data", 32'(busy), 32'd1);
        end
        chk("running_parity", 32'(running_parity), 32'(rp));
        if (gaps) idle($urandom_range(0, 2), 1'b1);
        e.d  = d;
        e.pe = (^d) ^ p ^ m;
        if (e.pe) exp_cnt = sat_inc(exp_cnt);
        e.cnt = exp_cnt;
        fvq.push_back(e);
        drive(1'b0, p, ~m);
        chk("frame_valid_latency", 32'(frame_valid), 32'd1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_bit   = 1'b0;
        bus.odd_mode = 1'b0;
        do_reset();
        idle(2, 1'b0);

        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);  // even, good
        idle(1, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);  // odd, bad
        idle(1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);  // odd, good
        idle(1, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);  // stalls between bits
        idle(2, 1'b0);
        chk("busy_idle", 32'(busy), 32'd0);

        partial(3, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);  // SOF mid-frame
        idle(2, 1'b0);

        do_reset();
        for (int f = 0; f < 5; f++) send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);

        partial(4, 1'b0);
        do_reset();
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);

        chk("fv_queue_drained", 32'(fvq.size()), 32'd0);
        chk("fe_queue_drained", 32'(feq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
- Serial even/odd parity checker for framed bit streams. It is the parametrised successor of the single-bit parity detector.
- Accepts a frame of DATA_BITS data bits, LSB first, followed by one parity bit. A valid/stall handshake qualifies each bit.
- Reassembles the data word and flags parity and framing errors. Keeps a saturating error count.
- Sits behind a serial receive path and feeds the downstream word consumer.

Parameters:
DATA_BITS, 8, data bits per frame (>=1), excluding the parity bit
CNT_BITS, 8, width of the saturating error counter (>=1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_bit/in_sof are valid this cycle; when low, no bit is consumed
in_bit  input  1  serial data/parity bit
in_sof  input  1  start of frame; when in_valid=1, in_bit is data bit 0
odd_mode  input  1  0=even parity, 1=odd parity; sampled on the accepted SOF bit
data_out  output  DATA_BITS  reassembled word; bit i = i-th data bit received
frame_valid  output  1  one-cycle pulse: frame complete, data_out/parity_err valid
parity_err  output  1  parity mismatch, qualified by frame_valid
framing_err  output  1  one-cycle pulse: SOF received mid-frame
running_parity  output  1  XOR of data bits accepted so far in the current frame
busy  output  1  state != IDLE
err_count  output  CNT_BITS  saturating count of parity_err + framing_err events

Behaviour:
- Reset: state IDLE. All outputs 0, including data_out, err_count, bit counter, running_parity and the latched mode.
- Reset mid-frame discards the partial frame and produces no pulses.
- A bit is accepted on a rising clk edge with in_valid=1. If in_valid=0, all state holds (stall); there is no timeout.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - Accepted bit with in_sof=0 is ignored.
  - Accepted bit with in_sof=1: store the bit as data bit 0, running_parity<=in_bit, latch odd_mode, cnt<=1.
  - Next state is PARITY if DATA_BITS==1, else DATA.
- DATA:
  - Accepted bit with in_sof=0: store at index cnt, running_parity ^= in_bit, cnt++.
  - After the bit at index DATA_BITS-1 is stored, go to PARITY.
- PARITY:
  - Accepted bit with in_sof=0: parity_err <= running_parity ^ in_bit ^ mode.
  - Even mode requires an even number of ones over data+parity; odd mode requires an odd number.
  - frame_valid<=1 for exactly one cycle (latency: 1 cycle after the parity bit edge).
  - running_parity<=0, next state IDLE.
  - A SOF bit accepted in the cycle frame_valid is high starts the next frame (back-to-back, zero-gap).
- SOF mid-frame (accepted in_sof=1 in DATA or PARITY):
  - framing_err pulses for 1 cycle; the partial frame is dropped and frame_valid is not asserted.
  - The bit is treated as a new data bit 0, exactly as the IDLE SOF action (odd_mode re-latched).
- data_out:
  - Bits update as they arrive; the word is only meaningful while frame_valid=1.
  - data_out holds its value until the next SOF.
- parity_err:
  - Registered; stays valid with frame_valid.
  - Holds its last value otherwise; consumers only sample it qualified.
- err_count:
  - +1 on each parity_err=1 frame_valid pulse and on each framing_err pulse.
  - The two events are mutually exclusive per cycle.
  - Saturates at 2^CNT_BITS-1; cleared only by reset.
- odd_mode changes mid-frame have no effect on the current frame.

Decomposition:
- Shared package parity_pkg holds:
  - typedef enum logic [1:0] {IDLE, DATA, PARITY} frame_state_t
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1
- One natural sub-module: sat_counter (parameter WIDTH; inputs clk, reset, inc; output count). It implements err_count.

Test Plan:
- Even, 0xA5: bits 1,0,1,0,0,1,0,1 then parity 0 -> frame_valid pulses 1 cycle after parity edge; data_out=0xA5; parity_err=0; err_count=0.
- Odd mode, same frame (parity 0) -> parity_err=1, err_count=1. Repeat with parity 1 -> parity_err=0, err_count stays 1.
- 0x3C with random in_valid gaps, parity 0, even -> identical result to the gap-free case; busy=1 throughout, running_parity=0 after bit 7.
- SOF after 3 data bits, then a full 0xFF frame with parity 0 -> framing_err 1-cycle pulse, err_count+1, then frame_valid with data_out=0xFF, parity_err=0.
- CNT_BITS=2, 5 consecutive bad-parity frames sent back-to-back -> err_count 1,2,3,3,3; one frame_valid per frame with no lost frames.
- reset=1 after 4 data bits -> all outputs 0, state IDLE; the following good frame 0x01 (parity 1, even) -> data_out=0x01, parity_err=0.
